// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with per-register busy scoreboard
// Optional same-cycle write-to-read bypass: define REG_FILE_MP_BYPASS_EN.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en0,
    input  logic [ADDR_W-1:0]        wr_addr0,
    input  logic [DATA_W-1:0]        wr_data0,
    input  logic                     wr_en1,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic [DATA_W-1:0]        wr_data1,
    input  logic                     res_en,
    input  logic [ADDR_W-1:0]        res_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic              wrOk0, wrOk1, resOk;
    logic              cntInc, cntDec0, cntDec1;

    // Register 0 is inert when hard-wired, so its writes and reservations are filtered here.
    always_comb begin
        wrOk0    = wr_en0 && !((ZERO_REG != 0) && (wr_addr0 == '0));
        wrOk1    = wr_en1 && !((ZERO_REG != 0) && (wr_addr1 == '0));
        resOk    = res_en && !((ZERO_REG != 0) && (res_addr == '0));
        busyNext = busy;
        if (wrOk0) busyNext[wr_addr0] = 1'b0;
        if (wrOk1) busyNext[wr_addr1] = 1'b0;
        if (resOk) busyNext[res_addr] = 1'b1;
        cntInc  = resOk && !busy[res_addr];
        cntDec0 = wrOk0 && busy[wr_addr0] && !(resOk && (res_addr == wr_addr0));
        // Same address on both ports clears only one bit.
        cntDec1 = wrOk1 && busy[wr_addr1] && !(resOk && (res_addr == wr_addr1))
                  && !(wrOk0 && (wr_addr0 == wr_addr1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wrOk0) regs[wr_addr0] <= wr_data0;
            if (wrOk1) regs[wr_addr1] <= wr_data1;
            busy     <= busyNext;
            busy_cnt <= busy_cnt + {{ADDR_W{1'b0}}, cntInc}
                        - {{ADDR_W{1'b0}}, cntDec0} - {{ADDR_W{1'b0}}, cntDec1};
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bsy;
        logic              isZero;

        assign addr   = rd_addr[k*ADDR_W +: ADDR_W];
        assign isZero = (ZERO_REG != 0) && (addr == '0);

`ifdef REG_FILE_MP_BYPASS_EN
        logic hit0, hit1;
        assign hit0 = wrOk0 && (wr_addr0 == addr);
        assign hit1 = wrOk1 && (wr_addr1 == addr);
        assign data = hit1 ? wr_data1 : hit0 ? wr_data0 : isZero ? '0 : regs[addr];
        assign bsy  = (hit0 || hit1) ? busyNext[addr] : busy[addr];
`else
        assign data = isZero ? '0 : regs[addr];
        assign bsy  = busy[addr];
`endif

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]                  = bsy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed vector bench for reg_file_mp
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en0, wr_en1, res_en;
    logic [4:0]  wr_addr0, wr_addr1, res_addr;
    logic [31:0] wr_data0, wr_data1;
    logic [5:0]  busy_cnt;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .res_en(res_en), .res_addr(res_addr), .busy_cnt(busy_cnt)
    );

    typedef struct {
        logic        e0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        e1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] x0;
        logic [31:0] x1;
        logic [1:0]  xb;
        logic [5:0]  xc;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic re, input logic [4:0] ra,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] x0, input logic [31:0] x1,
                                input logic [1:0] xb, input logic [5:0] xc);
        vec_t v;
        v.e0 = e0; v.a0 = a0; v.d0 = d0; v.e1 = e1; v.a1 = a1; v.d1 = d1;
        v.re = re; v.ra = ra; v.r0 = r0; v.r1 = r1;
        v.x0 = x0; v.x1 = x1; v.xb = xb; v.xc = xc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en0 = 1'b0; wr_en1 = 1'b0; res_en = 1'b0;
    endtask

    task automatic checkAll(input string tag, input logic [31:0] x0, input logic [31:0] x1,
                            input logic [1:0] xb, input logic [5:0] xc);
        check({tag, ".rd0"}, rd_data[31:0], x0);
        check({tag, ".rd1"}, rd_data[63:32], x1);
        check({tag, ".busy"}, {30'd0, rd_busy}, {30'd0, xb});
        check({tag, ".cnt"}, {26'd0, busy_cnt}, {26'd0, xc});
    endtask

    initial begin
        //            e0 a0  d0            e1 a1  d1            re ra  r0  r1  x0            x1            xb     xc
        vecs[0]  = mk(1, 5,  32'h0000_000C, 0, 0,  0,            0, 0,  5,  4,  32'h0000_000C, 32'h0,        2'b00, 0);
        vecs[1]  = mk(1, 7,  32'h11,        1, 7,  32'h22,       0, 0,  7,  5,  32'h22,        32'hC,        2'b00, 0);
        vecs[2]  = mk(1, 0,  32'hDEAD,      0, 0,  0,            1, 0,  0,  7,  32'h0,         32'h22,       2'b00, 0);
        vecs[3]  = mk(0, 0,  0,             0, 0,  0,            1, 2,  2,  3,  32'h0,         32'h0,        2'b01, 1);
        vecs[4]  = mk(0, 0,  0,             0, 0,  0,            1, 3,  2,  3,  32'h0,         32'h0,        2'b11, 2);
        vecs[5]  = mk(0, 0,  0,             0, 0,  0,            1, 4,  4,  2,  32'h0,         32'h0,        2'b11, 3);
        vecs[6]  = mk(1, 2,  32'hA2,        1, 3,  32'hA3,       1, 3,  2,  3,  32'hA2,        32'hA3,       2'b10, 2);
        vecs[7]  = mk(0, 0,  0,             0, 0,  0,            1, 4,  4,  3,  32'h0,         32'hA3,       2'b11, 2);
        vecs[8]  = mk(0, 0,  0,             1, 6,  32'h66,       0, 0,  6,  4,  32'h66,        32'h0,        2'b10, 2);
        vecs[9]  = mk(1, 4,  32'h44,        1, 3,  32'h33,       0, 0,  4,  3,  32'h44,        32'h33,       2'b00, 0);
        vecs[10] = mk(1, 8,  32'h88,        0, 0,  0,            1, 8,  8,  0,  32'h88,        32'h0,        2'b01, 1);
        vecs[11] = mk(1, 8,  32'h89,        1, 8,  32'h8A,       0, 0,  8,  8,  32'h8A,        32'h8A,       2'b00, 0);
        vecs[12] = mk(0, 0,  0,             0, 0,  0,            1, 31, 31, 30, 32'h0,         32'h0,        2'b01, 1);
        vecs[13] = mk(0, 0,  0,             1, 31, 32'hFFFF_FFFF, 0, 0, 31, 0,  32'hFFFF_FFFF, 32'h0,        2'b00, 0);

        // Reset held two cycles against a live write.
        rst = 1'b0; idle(); rd_addr = {5'd0, 5'd3};
        wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'hFF;
        wr_addr1 = '0; wr_data1 = '0; res_addr = 5'd3; res_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; idle();
        #1 checkAll("reset", 32'h0, 32'h0, 2'b00, 0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            wr_en0 = vecs[i].e0; wr_addr0 = vecs[i].a0; wr_data0 = vecs[i].d0;
            wr_en1 = vecs[i].e1; wr_addr1 = vecs[i].a1; wr_data1 = vecs[i].d1;
            res_en = vecs[i].re; res_addr = vecs[i].ra;
            rd_addr = {vecs[i].r1, vecs[i].r0};
            @(posedge clk);
            #1 idle();
            #1 checkAll($sformatf("vec%0d", i), vecs[i].x0, vecs[i].x1, vecs[i].xb, vecs[i].xc);
        end

        // Same-cycle read of a register being written.
        @(negedge clk);
        wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'h12; rd_addr = {5'd9, 5'd9};
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'h55;
        #1;
`ifdef REG_FILE_MP_BYPASS_EN
        check("bypass.same", rd_data[31:0], 32'h55);
`else
        check("bypass.same", rd_data[31:0], 32'h12);
`endif
        @(posedge clk);
        #1 idle();
        #1 check("bypass.next", rd_data[63:32], 32'h55);

        // Mid-run reset beats a simultaneous reservation and write.
        @(negedge clk);
        res_en = 1'b1; res_addr = 5'd10; wr_en1 = 1'b1; wr_addr1 = 5'd5; wr_data1 = 32'h77;
        rst = 1'b0; rd_addr = {5'd10, 5'd5};
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; idle();
        #1 checkAll("rereset", 32'h0, 32'h0, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
